// File: rtl/nonrestoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the non-restoring signed divider.
//   state_e    : controller states (IDLE -> CALC -> CORR -> IDLE)
//   cnt_width  : bits needed for an iteration counter that holds WIDTH
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider_if
// Start/done handshake bundle between an issuing stage and the divider.
//   start        : request, only taken while the divider is idle
//   dividend     : signed dividend (WIDTH bits)
//   divisor      : signed divisor  (WIDTH bits)
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   quotient     : signed quotient, truncated toward zero
//   remainder    : signed remainder, takes the sign of the dividend
//   div_by_zero  : divisor was zero (meaningful with done)
// Modports: master (issuer) drives the request, slave (divider) answers.
// -----------------------------------------------------------------------------
interface nonrestoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider_step.sv
// -----------------------------------------------------------------------------
// nonrestoring_step
// One combinational iteration of non-restoring division on magnitudes.
//   p_i : partial remainder, WIDTH+1 bits two's complement
//   q_i : quotient/dividend shift register, WIDTH bits
//   d_i : divisor magnitude, WIDTH bits unsigned
//   p_o : next partial remainder
//   q_o : next quotient shift register
// -----------------------------------------------------------------------------
module nonrestoring_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;

  // {P,Q} <<= 1 : the top dividend bit moves into P.
  assign p_shift = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign d_ext   = {1'b0, d_i};

  // Add/subtract choice uses the sign of P before the shift.
  assign p_o = p_i[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);

  // New quotient bit is 1 when the new partial remainder is non-negative.
  assign q_o = {q_i[WIDTH-2:0], ~p_o[WIDTH]};

endmodule

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
// Sequential signed divider: WIDTH iterations of non-restoring division on the
// operand magnitudes, then one correction cycle that restores a negative
// remainder and applies the result signs. Results appear WIDTH+1 edges after
// the accepted start edge together with a one-cycle done pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : nonrestoring_divider_if.slave (start/operands in, busy/done/results out)
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor skips CALC; done on edge 1 with quotient all-ones,
//               remainder = dividend, div_by_zero = 1
//   undefined : no check, div_by_zero tied low
// -----------------------------------------------------------------------------
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  nonrestoring_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] d_q;
  logic             neg_y_q;
  logic             neg_d_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             accept;

`ifdef DIV_ZERO_DETECT_EN
  logic             dz_q;
  logic             dbz_q;
`endif

  // Magnitudes as unsigned WIDTH-bit values so |MIN| = 2^(WIDTH-1) still fits.
  assign y_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign d_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;

  // A start in the done cycle is refused so the issuer sees the pulse first.
  assign accept = bus.start && !done_q;

  nonrestoring_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p_i(p_q),
    .q_i(acc_q),
    .d_i(d_q),
    .p_o(p_d),
    .q_o(acc_d)
  );

  // Correction: a negative final P is restored by adding D back. P's sign bit
  // only selects the add; the corrected magnitude fits in WIDTH bits.
  assign rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];
  assign rem_d   = neg_y_q ? (~rem_mag + 1'b1) : rem_mag;

`ifdef DIV_ZERO_DETECT_EN
  assign quo_d = dz_q ? '1 : ((neg_y_q ^ neg_d_q) ? (~acc_q + 1'b1) : acc_q);
`else
  assign quo_d = (neg_y_q ^ neg_d_q) ? (~acc_q + 1'b1) : acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      neg_y_q <= 1'b0;
      neg_d_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_y_q <= bus.dividend[WIDTH-1];
            neg_d_q <= bus.divisor[WIDTH-1];
            d_q     <= d_mag;
            p_q     <= '0;
            acc_q   <= y_mag;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CALC;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= (bus.divisor == '0);
            if (bus.divisor == '0) begin
              // Park |dividend| in P so the normal sign fix-up yields the dividend.
              p_q     <= {1'b0, y_mag};
              state_q <= CORR;
            end
`endif
          end
        end
        CALC: begin
          p_q   <= p_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= CORR;
          end
        end
        CORR: begin
          quo_q   <= quo_d;
          rem_q   <= rem_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
          dbz_q   <= dz_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// tb_nonrestoring_divider
// Self-checking bench for nonrestoring_divider (WIDTH=4). Expected results come
// from integer / and % on sign-extended operands.
// Honors DIV_ZERO_DETECT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_nonrestoring_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nonrestoring_divider_if #(.WIDTH(W)) bus ();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference: signed integer division truncating toward zero.
  task automatic model(input logic [W-1:0] y, input logic [W-1:0] d,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    int a;
    int b;
    a = int'($signed(y));
    b = int'($signed(d));
    q = W'(a / b);
    r = W'(a % b);
  endtask

  // Issue one operation; report edges to done (-1 on timeout) and busy cycles.
  task automatic do_op(input logic [W-1:0] y, input logic [W-1:0] d,
                       output int lat, output int busy_cyc);
    for (int i = 0; i < 100 && (bus.busy || bus.done); i++) @(negedge clk);
    @(negedge clk);
    bus.dividend = y;
    bus.divisor  = d;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat      = -1;
    busy_cyc = bus.busy ? 1 : 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.quotient !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: busy=%b done=%b q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(4'd7, 4'd2, lat, bc);
    $display("op 7/2: lat=%0d busy=%0d q=%h r=%h", lat, bc, bus.quotient, bus.remainder);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", lat); end
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 5", bc); end
    n_checks++; if (bus.quotient !== 4'd3) begin n_fail++; $display("FAIL basic_q: got %h want 3", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'd1) begin n_fail++; $display("FAIL basic_r: got %h want 1", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_signs();
    logic [W-1:0] ys [10];
    logic [W-1:0] ds [10];
    logic [W-1:0] eq, er;
    int lat, bc;
    ys = '{4'h9, 4'h7, 4'h9, 4'h8, 4'h8, 4'h3, 4'h0, 4'h2, 4'hF, 4'h7};
    ds = '{4'h2, 4'hE, 4'hE, 4'hF, 4'h3, 4'h5, 4'h3, 4'h9, 4'h1, 4'h7};
    for (int i = 0; i < 10; i++) begin
      do_op(ys[i], ds[i], lat, bc);
      model(ys[i], ds[i], eq, er);
      $display("op %h/%h: lat=%0d q=%h r=%h", ys[i], ds[i], lat, bus.quotient, bus.remainder);
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL signs_latency %h/%h: got %0d want 5", ys[i], ds[i], lat); end
      n_checks++; if (bus.quotient !== eq) begin n_fail++; $display("FAIL signs_q %h/%h: got %h want %h", ys[i], ds[i], bus.quotient, eq); end
      n_checks++; if (bus.remainder !== er) begin n_fail++; $display("FAIL signs_r %h/%h: got %h want %h", ys[i], ds[i], bus.remainder, er); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    do_op(4'd5, 4'd0, lat, bc);
    $display("op 5/0: lat=%0d q=%h r=%h dbz=%b", lat, bus.quotient, bus.remainder, bus.div_by_zero);
`ifdef DIV_ZERO_DETECT_EN
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_checks++; if (bus.quotient !== 4'hF) begin n_fail++; $display("FAIL dz_q: got %h want f", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'd5) begin n_fail++; $display("FAIL dz_r: got %h want 5", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", bus.div_by_zero); end
`else
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL dz_latency: got %0d want 5", lat); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag: got %b want 0", bus.div_by_zero); end
`endif
    do_op(4'd6, 4'd3, lat, bc);
    $display("op 6/3: lat=%0d q=%h r=%h dbz=%b", lat, bus.quotient, bus.remainder, bus.div_by_zero);
    n_checks++; if (bus.quotient !== 4'd2) begin n_fail++; $display("FAIL dz_next_q: got %h want 2", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'd0) begin n_fail++; $display("FAIL dz_next_r: got %h want 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    logic [W-1:0] q_seen = '0, r_seen = '0;
    for (int i = 0; i < 100 && (bus.busy || bus.done); i++) @(negedge clk);
    @(negedge clk);
    bus.dividend = 4'd7; bus.divisor = 4'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.dividend = 4'd1; bus.divisor = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin dones++; q_seen = bus.quotient; r_seen = bus.remainder; end
    end
    $display("busy-start: dones=%0d q=%h r=%h", dones, q_seen, r_seen);
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignored_dones: got %0d want 1", dones); end
    n_checks++; if (q_seen !== 4'd3) begin n_fail++; $display("FAIL ignored_q: got %h want 3", q_seen); end
    n_checks++; if (r_seen !== 4'd1) begin n_fail++; $display("FAIL ignored_r: got %h want 1", r_seen); end
  endtask

  task automatic test_done_cycle_start();
    int lat, bc;
    do_op(4'd6, 4'd3, lat, bc);
    // Still inside the done cycle: this start must be refused.
    bus.dividend = 4'd1; bus.divisor = 4'd1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    $display("done-cycle start: busy=%b q=%h", bus.busy, bus.quotient);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL donecycle_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.quotient !== 4'd2) begin n_fail++; $display("FAIL donecycle_hold_q: got %h want 2", bus.quotient); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat, bc;
    for (int i = 0; i < 100 && (bus.busy || bus.done); i++) @(negedge clk);
    @(negedge clk);
    bus.dividend = 4'd7; bus.divisor = 4'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("mid reset: busy=%b done=%b q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.quotient !== 4'd0) begin n_fail++; $display("FAIL midrst_q: got %h want 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'd0) begin n_fail++; $display("FAIL midrst_r: got %h want 0", bus.remainder); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    do_op(4'd6, 4'd4, lat, bc);
    $display("op 6/4: lat=%0d q=%h r=%h", lat, bus.quotient, bus.remainder);
    n_checks++; if (bus.quotient !== 4'd1) begin n_fail++; $display("FAIL midrst_next_q: got %h want 1", bus.quotient); end
    n_checks++; if (bus.remainder !== 4'd2) begin n_fail++; $display("FAIL midrst_next_r: got %h want 2", bus.remainder); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] y, d, eq, er;
    int lat, bc;
    for (int i = 0; i < 16 * 15 + 60; i++) begin
      if (i < 240) begin
        y = W'(i / 15);
        d = W'(i % 15 + 1);
      end else begin
        y = W'($urandom_range(0, 15));
        d = W'($urandom_range(1, 15));
      end
      do_op(y, d, lat, bc);
      model(y, d, eq, er);
      $display("sweep %h/%h: lat=%0d q=%h r=%h", y, d, lat, bus.quotient, bus.remainder);
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL sweep_latency %h/%h: got %0d want 5", y, d, lat); end
      n_checks++; if (bus.quotient !== eq) begin n_fail++; $display("FAIL sweep_q %h/%h: got %h want %h", y, d, bus.quotient, eq); end
      n_checks++; if (bus.remainder !== er) begin n_fail++; $display("FAIL sweep_r %h/%h: got %h want %h", y, d, bus.remainder, er); end
      n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL sweep_dbz %h/%h: got %b want 0", y, d, bus.div_by_zero); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_ignored_start();
    test_done_cycle_start();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
